// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO pair, with MTHI/MTLO write ports.
// Latency: WIDTH+1 cycles from the sampled start to done (WIDTH RUN cycles plus one FIX cycle).
// No backpressure: busy stalls the pipeline; start, hi_we and lo_we are ignored while busy.
//
// Ports:
//   clk, reset (async, active-low)
//   start, op[1:0] (00 MULT, 01 MULTU, 10 DIV, 11 DIVU), a (rs), b (rt)
//   hi_we, lo_we, wdata : MTHI/MTLO writes, honoured only when idle and start is low
//   busy, done, div_by_zero, hi, lo : all registered
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // Multiply: {partial product high, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;  // raw dividend for the divide-by-zero result
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;      // product / quotient sign
    logic               rem_neg_q, rem_neg_d;
    logic               b_zero_q, b_zero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic               div_ok;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    // op[0] set means unsigned: operands are taken raw.
    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];
    // The most negative value maps to 1 << (WIDTH-1), which is its correct unsigned magnitude.
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // Shift-add step: add the multiplicand when the current multiplier bit is set.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? dsr_q : {WIDTH{1'b0}})};

    // Restoring step: shift the next dividend bit into the remainder, try to subtract.
    // A set top bit of the trial means the subtraction borrowed and is discarded.
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_trial = div_shift - {1'b0, dsr_q};
    assign div_ok    = ~div_trial[WIDTH];

    assign prod = neg_q ? -acc_q : acc_q;
    assign quo  = acc_q[WIDTH-1:0];
    assign rem  = acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        dsr_d     = dsr_q;
        a_raw_d   = a_raw_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        b_zero_d  = b_zero_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d  = op[1];
                    neg_d     = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    b_zero_d  = (b == '0);
                    a_raw_d   = a;
                    acc_d     = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                    dsr_d     = op[1] ? b_mag : a_mag;
                    cnt_d     = CW'(WIDTH - 1);
                    dbz_d     = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            RUN: begin
                if (is_div_q) begin
                    acc_d = {(div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                             acc_q[WIDTH-2:0], div_ok};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIX: begin
                if (is_div_q) begin
                    if (b_zero_q) begin
                        lo_d = '1;
                        hi_d = a_raw_q;
                    end else begin
                        lo_d = neg_q ? -quo : quo;
                        hi_d = rem_neg_q ? -rem : rem;
                    end
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                dbz_d   = is_div_q & b_zero_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            dsr_q     <= '0;
            a_raw_q   <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            b_zero_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            dsr_q     <= dsr_d;
            a_raw_q   <= a_raw_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            b_zero_q  <= b_zero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised and directed bench for mult_div_unit at WIDTH=32 and WIDTH=8.
// Expected results come from an arithmetic reference model and are queued at issue time;
// per-instance monitors pop and compare whenever done is seen, also checking latency and busy length.
module tb_mult_div_unit;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic        start32 = 0, hi_we32 = 0, lo_we32 = 0;
    logic [1:0]  op32 = 0;
    logic [31:0] a32 = 0, b32 = 0, wdata32 = 0;
    logic        busy32, done32, dbz32;
    logic [31:0] hi32, lo32;

    logic        start8 = 0, hi_we8 = 0, lo_we8 = 0;
    logic [1:0]  op8 = 0;
    logic [7:0]  a8 = 0, b8 = 0, wdata8 = 0;
    logic        busy8, done8, dbz8;
    logic [7:0]  hi8, lo8;

    mult_div_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
        .hi_we(hi_we32), .lo_we(lo_we32), .wdata(wdata32),
        .busy(busy32), .done(done32), .div_by_zero(dbz32), .hi(hi32), .lo(lo32)
    );

    mult_div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .hi_we(hi_we8), .lo_we(lo_we8), .wdata(wdata8),
        .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          due;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];

    int n_vec = 0;
    int n_err = 0;
    int blen32 = 0;
    int blen8 = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Plain integer arithmetic at width w: signed values are sign-extended into longint.
    function automatic void model(input int w, input logic [1:0] o, input logic [31:0] x,
                                  input logic [31:0] y, output logic [31:0] h,
                                  output logic [31:0] l, output logic dz);
        longint unsigned m, ua, ub, p;
        longint sa, sb;
        m  = (64'd1 << w) - 64'd1;
        ua = {32'd0, x} & m;
        ub = {32'd0, y} & m;
        sa = longint'(ua);
        sb = longint'(ub);
        if (ua[w-1]) sa = sa - (longint'(1) << w);
        if (ub[w-1]) sb = sb - (longint'(1) << w);
        dz = 1'b0;
        p  = 64'd0;
        h  = 32'd0;
        l  = 32'd0;
        case (o)
            MULT, MULTU: begin
                p = (o == MULT) ? $unsigned(sa * sb) : ua * ub;
                h = 32'((p >> w) & m);
                l = 32'(p & m);
            end
            default: begin
                if (ub == 64'd0) begin
                    h  = 32'(ua);
                    l  = 32'(m);
                    dz = 1'b1;
                end else if (o == DIV) begin
                    h = 32'($unsigned(sa % sb) & m);
                    l = 32'($unsigned(sa / sb) & m);
                end else begin
                    h = 32'(ua % ub);
                    l = 32'(ua / ub);
                end
            end
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            blen32 = 0;
        end else begin
            if (busy32) blen32++;
            else if (blen32 != 0) begin
                cmp("busy_len32", 64'(blen32), 64'd33);
                blen32 = 0;
            end
            if (done32) begin
                if (q32.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL spurious_done32: got done=1, expected no pending op (cycle %0d)", cyc);
                end else begin
                    e = q32.pop_front();
                    cmp("hi32", 64'(hi32), 64'(e.hi));
                    cmp("lo32", 64'(lo32), 64'(e.lo));
                    cmp("dbz32", 64'(dbz32), 64'(e.dz));
                    cmp("latency32", 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            blen8 = 0;
        end else begin
            if (busy8) blen8++;
            else if (blen8 != 0) begin
                cmp("busy_len8", 64'(blen8), 64'd9);
                blen8 = 0;
            end
            if (done8) begin
                if (q8.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL spurious_done8: got done=1, expected no pending op (cycle %0d)", cyc);
                end else begin
                    e = q8.pop_front();
                    cmp("hi8", 64'(hi8), 64'(e.hi[7:0]));
                    cmp("lo8", 64'(lo8), 64'(e.lo[7:0]));
                    cmp("dbz8", 64'(dbz8), 64'(e.dz));
                    cmp("latency8", 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    // Called at a negedge; start is sampled at the next rising edge.
    task automatic issue(input bit s8, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        int   w;
        w = s8 ? 8 : 32;
        model(w, o, x, y, e.hi, e.lo, e.dz);
        e.due = cyc + w + 2;
        if (s8) begin
            start8 = 1; op8 = o; a8 = x[7:0]; b8 = y[7:0];
            q8.push_back(e);
        end else begin
            start32 = 1; op32 = o; a32 = x; b32 = y;
            q32.push_back(e);
        end
        @(negedge clk);
        start8  = 0;
        start32 = 0;
    endtask

    // Returns at the negedge where done is high, so a following issue is back-to-back.
    task automatic wait_done(input bit s8);
        for (int i = 0; i < 80; i++) begin
            if (s8 ? done8 : done32) return;
            @(negedge clk);
        end
        n_vec++; n_err++;
        $display("FAIL timeout%0d: got no done within 80 cycles, expected done", s8 ? 8 : 32);
    endtask

    // Illegal-while-busy activity: a new start, changed operands and HI/LO writes.
    task automatic poke(input bit s8);
        if (s8) begin
            start8 = 1; op8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
            hi_we8 = 1; lo_we8 = 1; wdata8 = 8'($urandom);
        end else begin
            start32 = 1; op32 = 2'($urandom); a32 = $urandom; b32 = $urandom;
            hi_we32 = 1; lo_we32 = 1; wdata32 = $urandom;
        end
        @(negedge clk);
        start8 = 0; hi_we8 = 0; lo_we8 = 0;
        start32 = 0; hi_we32 = 0; lo_we32 = 0;
    endtask

    function automatic logic [31:0] pick(input int w);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        case ($urandom_range(0, 7))
            0: pick = 32'd0;
            1: pick = 32'd1;
            2: pick = m;
            3: pick = 32'd1 << (w - 1);
            default: pick = $urandom & m;
        endcase
    endfunction

    task automatic reset_mid_op();
        #2 reset = 0;
        #1;
        cmp("rst_busy32", 64'(busy32), 64'd0);
        cmp("rst_done32", 64'(done32), 64'd0);
        cmp("rst_hi32", 64'(hi32), 64'd0);
        cmp("rst_lo32", 64'(lo32), 64'd0);
        cmp("rst_dbz32", 64'(dbz32), 64'd0);
        cmp("rst_busy8", 64'(busy8), 64'd0);
        cmp("rst_hi8", 64'(hi8), 64'd0);
        cmp("rst_lo8", 64'(lo8), 64'd0);
        q32.delete();
        q8.delete();
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] prev_lo, prev_hi, wd;

        repeat (3) @(negedge clk);
        cmp("reset_busy", 64'(busy32), 64'd0);
        cmp("reset_done", 64'(done32), 64'd0);
        cmp("reset_dbz", 64'(dbz32), 64'd0);
        cmp("reset_hi", 64'(hi32), 64'd0);
        cmp("reset_lo", 64'(lo32), 64'd0);
        reset = 1;
        @(negedge clk);

        // Directed cases from the test plan, checked through the scoreboard.
        issue(0, MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done(0);
        @(negedge clk);
        issue(0, MULT, -32'sd3, 32'd5);                wait_done(0);
        issue(0, DIV, -32'sd7, 32'd2);                 wait_done(0);
        issue(0, DIVU, 32'd7, 32'd0);                  wait_done(0);
        issue(0, MULTU, 32'd2, 32'd3);
        cmp("dbz_cleared_on_start", 64'(dbz32), 64'd0);
        wait_done(0);
        issue(0, DIV, 32'h8000_0000, 32'hFFFF_FFFF);   wait_done(0);
        @(negedge clk);

        // MTHI and MTLO together in IDLE.
        wd = $urandom;
        hi_we32 = 1; lo_we32 = 1; wdata32 = wd;
        @(negedge clk);
        hi_we32 = 0; lo_we32 = 0;
        cmp("mthi", 64'(hi32), 64'(wd));
        cmp("mtlo", 64'(lo32), 64'(wd));

        // Start and MTLO in the same cycle: the write is dropped.
        prev_lo = lo32;
        prev_hi = hi32;
        lo_we32 = 1; hi_we32 = 1; wdata32 = 32'h5555_5555;
        issue(0, MULTU, 32'd3, 32'd4);
        lo_we32 = 0; hi_we32 = 0;
        cmp("start_wins_lo", 64'(lo32), 64'(prev_lo));
        cmp("start_wins_hi", 64'(hi32), 64'(prev_hi));
        wait_done(0);
        @(negedge clk);

        // Interference during MULTU 3 x 4.
        issue(0, MULTU, 32'd3, 32'd4);
        repeat (3) @(negedge clk);
        start32 = 1; op32 = DIVU; a32 = 32'd9; b32 = 32'd3;
        @(negedge clk);
        start32 = 0;
        hi_we32 = 1; wdata32 = 32'h0000_DEAD;
        @(negedge clk);
        hi_we32 = 0;
        wait_done(0);
        lo_we32 = 1; wdata32 = 32'h0000_1234;
        @(negedge clk);
        lo_we32 = 0;
        cmp("mtlo_after_done", 64'(lo32), 64'h1234);
        cmp("hi_after_ignored_mthi", 64'(hi32), 64'd0);

        // Reset in the middle of a DIV, then a normal op.
        issue(0, DIV, -32'sd100, 32'd7);
        repeat (8) @(negedge clk);
        reset_mid_op();
        issue(0, MULTU, 32'd2, 32'd2); wait_done(0);

        // Random back-to-back traffic with occasional illegal activity while busy.
        for (int n = 0; n < 150; n++) begin
            issue(0, 2'($urandom_range(0, 3)), pick(32), pick(32));
            if ($urandom_range(0, 2) == 0) poke(0);
            wait_done(0);
        end
        @(negedge clk);

        // WIDTH=8 instance.
        issue(1, DIV, 32'h85, 32'd3);
        repeat (4) @(negedge clk);
        reset_mid_op();
        issue(1, MULTU, 32'd2, 32'd2); wait_done(1);
        issue(1, DIV, 32'h80, 32'hFF); wait_done(1);
        issue(1, DIVU, 32'h07, 32'h00); wait_done(1);
        for (int n = 0; n < 120; n++) begin
            issue(1, 2'($urandom_range(0, 3)), pick(8), pick(8));
            if ($urandom_range(0, 2) == 0) poke(1);
            wait_done(1);
        end

        repeat (3) @(negedge clk);
        cmp("q32_drained", 64'(q32.size()), 64'd0);
        cmp("q8_drained", 64'(q8.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
